// File: rtl/noc_out_arb_5to1.sv
// noc_out_arb_5to1: output-port arbiter for one NOC router output.
// Merges five input flit streams (N, S, W, E, L) into one registered output using
// round-robin arbitration with wormhole locking (head locks, tail/single releases).
// Optional feature macro: NOC_ARB_TYPE_CHECK_EN. When defined, body/tail flits seen
// while IDLE are handshaken but dropped, and the sticky err_o is raised.
module noc_out_arb_5to1 #(
  parameter int unsigned FLIT_W = 16,
  parameter int unsigned NPORTS = 5
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [FLIT_W-1:0] data_n_i,
  input  logic [FLIT_W-1:0] data_s_i,
  input  logic [FLIT_W-1:0] data_w_i,
  input  logic [FLIT_W-1:0] data_e_i,
  input  logic [FLIT_W-1:0] data_l_i,
  input  logic [NPORTS-1:0] valid_i,
  output logic [NPORTS-1:0] ready_o,
  output logic [FLIT_W-1:0] data_o,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [2:0]        grant_o,
  output logic              locked_o,
  output logic              err_o
);

  localparam int unsigned PTR_W = 3;
  localparam logic [1:0] TYPE_HEAD   = 2'b10;
  localparam logic [1:0] TYPE_BODY   = 2'b00;
  localparam logic [1:0] TYPE_TAIL   = 2'b01;
  localparam logic [1:0] TYPE_SINGLE = 2'b11;

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_LOCKED = 1'b1
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [PTR_W-1:0]   r_owner;
  logic [PTR_W-1:0]   r_rr_ptr;
  logic [FLIT_W-1:0]  r_data;
  logic               r_valid;

  logic [FLIT_W-1:0]  w_in_data [NPORTS];
  logic [PTR_W:0]     w_idx;
  logic [PTR_W-1:0]   w_cand;
  logic               w_cand_vld;
  logic [PTR_W-1:0]   w_sel;
  logic               w_sel_vld;
  logic               w_out_free;
  logic [FLIT_W-1:0]  w_flit;
  logic [1:0]         w_type;
  logic               w_acc;
  logic               w_drop;
  logic               w_fwd;
  logic               w_release;

  assign w_in_data[0] = data_n_i;
  assign w_in_data[1] = data_s_i;
  assign w_in_data[2] = data_w_i;
  assign w_in_data[3] = data_e_i;
  assign w_in_data[4] = data_l_i;

  // (p + 1) mod NPORTS for the round-robin pointer
  function automatic logic [PTR_W-1:0] inc_mod(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(NPORTS - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Round-robin search: first valid input starting at rr_ptr, wrapping mod NPORTS
  always_comb begin
    w_idx      = '0;
    w_cand     = '0;
    w_cand_vld = 1'b0;
    for (int i = NPORTS - 1; i >= 0; i--) begin
      w_idx = {1'b0, r_rr_ptr} + (PTR_W + 1)'(i);
      if (w_idx >= (PTR_W + 1)'(NPORTS)) begin
        w_idx = w_idx - (PTR_W + 1)'(NPORTS);
      end
      if (valid_i[w_idx[PTR_W-1:0]]) begin
        w_cand_vld = 1'b1;
        w_cand     = w_idx[PTR_W-1:0];
      end
    end
  end

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state: heads (and untyped-check bodies) lock, tail/single releases
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_fwd && (w_type == TYPE_HEAD || w_type == TYPE_BODY)) begin
          w_state_nxt = S_LOCKED;
        end
      end
      S_LOCKED: begin
        if (w_release) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output/handshake decode: selected input, ready, accept and drop qualifiers
  always_comb begin
    w_out_free = !r_valid || ready_i;
    w_sel      = (r_state == S_LOCKED) ? r_owner : w_cand;
    w_sel_vld  = (r_state == S_LOCKED) ? valid_i[r_owner] : w_cand_vld;
    ready_o    = '0;
    if (rst_ni && (r_state == S_LOCKED || w_cand_vld)) begin
      ready_o[w_sel] = w_out_free;
    end
    w_flit     = w_in_data[w_sel];
    w_type     = w_flit[FLIT_W-1 -: 2];
    w_acc      = rst_ni && w_sel_vld && w_out_free;
`ifdef NOC_ARB_TYPE_CHECK_EN
    w_drop     = (r_state == S_IDLE) && (w_type == TYPE_BODY || w_type == TYPE_TAIL);
`else
    w_drop     = 1'b0;
`endif
    w_fwd      = w_acc && !w_drop;
    w_release  = (r_state == S_LOCKED) && w_acc &&
                 (w_type == TYPE_TAIL || w_type == TYPE_SINGLE);
  end

  // Owner and round-robin pointer bookkeeping
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_owner  <= '0;
      r_rr_ptr <= '0;
    end else if (w_acc) begin
      if (r_state == S_IDLE) begin
        if (!w_drop) begin
          r_owner <= w_cand;
        end
        if (w_drop || w_type == TYPE_SINGLE || w_type == TYPE_TAIL) begin
          r_rr_ptr <= inc_mod(w_cand);
        end
      end else if (w_release) begin
        r_rr_ptr <= inc_mod(r_owner);
      end
    end
  end

  // Output register: load on forwarded flit, clear valid when downstream pops
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (w_fwd) begin
      r_valid <= 1'b1;
      r_data  <= w_flit;
    end else if (ready_i) begin
      r_valid <= 1'b0;
    end
  end

`ifdef NOC_ARB_TYPE_CHECK_EN
  logic r_err;

  // Sticky error on a body/tail arriving without a preceding head
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_err <= 1'b0;
    end else if (w_acc && w_drop) begin
      r_err <= 1'b1;
    end
  end

  assign err_o = r_err;
`else
  assign err_o = 1'b0;
`endif

  assign data_o   = r_data;
  assign valid_o  = r_valid;
  assign grant_o  = r_owner;
  assign locked_o = (r_state == S_LOCKED);

endmodule

// File: tb/tb_noc_out_arb_5to1.sv
// Directed testbench for noc_out_arb_5to1 with hand-computed expected values.
module tb_noc_out_arb_5to1;

  logic        clk_i;
  logic        rst_ni;
  logic [15:0] data_n_i, data_s_i, data_w_i, data_e_i, data_l_i;
  logic [4:0]  valid_i;
  logic [4:0]  ready_o;
  logic [15:0] data_o;
  logic        valid_o;
  logic        ready_i;
  logic [2:0]  grant_o;
  logic        locked_o;
  logic        err_o;

  int n_vec;
  int n_bad;

  noc_out_arb_5to1 u_dut (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .data_n_i (data_n_i),
    .data_s_i (data_s_i),
    .data_w_i (data_w_i),
    .data_e_i (data_e_i),
    .data_l_i (data_l_i),
    .valid_i  (valid_i),
    .ready_o  (ready_o),
    .data_o   (data_o),
    .valid_o  (valid_o),
    .ready_i  (ready_i),
    .grant_o  (grant_o),
    .locked_o (locked_o),
    .err_o    (err_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge so outputs are sampled away from it
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    logic [2:0]  exp_g [6];
    n_vec    = 0;
    n_bad    = 0;
    rst_ni   = 1'b0;
    ready_i  = 1'b1;
    valid_i  = 5'b11111;
    data_n_i = 16'hC000;
    data_s_i = 16'hC001;
    data_w_i = 16'hC002;
    data_e_i = 16'hC003;
    data_l_i = 16'hC004;
    #12;
    // Reset state, with inputs valid: ready must stay low
    chk("rst_ready", 32'(ready_o), 32'h0);
    chk("rst_valid", 32'(valid_o), 32'h0);
    chk("rst_data", 32'(data_o), 32'h0);
    chk("rst_grant", 32'(grant_o), 32'h0);
    chk("rst_locked", 32'(locked_o), 32'h0);
    chk("rst_err", 32'(err_o), 32'h0);
    valid_i = '0;
    tick();
    rst_ni = 1'b1;

    // Single on L
    data_l_i = 16'hC0A5;
    valid_i  = 5'b10000;
    #1;
    chk("l_ready", 32'(ready_o), 32'h10);
    tick();
    valid_i = '0;
    chk("l_data", 32'(data_o), 32'hC0A5);
    chk("l_valid", 32'(valid_o), 32'h1);
    chk("l_grant", 32'(grant_o), 32'h4);
    tick();
    chk("l_drain_valid", 32'(valid_o), 32'h0);
    chk("l_hold_data", 32'(data_o), 32'hC0A5);

    // Wormhole: N packet while E single waits (rr_ptr = 0 after wrap)
    data_n_i = 16'h8001;
    data_e_i = 16'hC0EE;
    valid_i  = 5'b01001;
    #1;
    chk("wh_head_ready", 32'(ready_o), 32'h01);
    tick();
    chk("wh_head_data", 32'(data_o), 32'h8001);
    chk("wh_head_locked", 32'(locked_o), 32'h1);
    data_n_i = 16'h0002;
    #1;
    chk("wh_body_ready", 32'(ready_o), 32'h01);
    tick();
    chk("wh_body_data", 32'(data_o), 32'h0002);
    chk("wh_body_locked", 32'(locked_o), 32'h1);
    data_n_i = 16'h4003;
    #1;
    chk("wh_tail_ready", 32'(ready_o), 32'h01);
    tick();
    chk("wh_tail_data", 32'(data_o), 32'h4003);
    chk("wh_tail_locked", 32'(locked_o), 32'h0);
    valid_i = 5'b01000;
    #1;
    chk("wh_e_ready", 32'(ready_o), 32'h08);
    tick();
    chk("wh_e_data", 32'(data_o), 32'hC0EE);
    chk("wh_e_grant", 32'(grant_o), 32'h3);
    valid_i = '0;
    tick();

    // All five offer singles continuously; rr_ptr is 4 here (after E)
    data_n_i = 16'hC000;
    data_s_i = 16'hC001;
    data_w_i = 16'hC002;
    data_e_i = 16'hC003;
    data_l_i = 16'hC004;
    valid_i  = 5'b11111;
    exp_g[0] = 3'd4; exp_g[1] = 3'd0; exp_g[2] = 3'd1;
    exp_g[3] = 3'd2; exp_g[4] = 3'd3; exp_g[5] = 3'd4;
    for (int i = 0; i < 6; i++) begin
      #1;
      chk("rr_ready", 32'(ready_o), 32'(5'b00001 << exp_g[i]));
      tick();
      chk("rr_grant", 32'(grant_o), 32'(exp_g[i]));
      chk("rr_data", 32'(data_o), 32'(16'hC000 + 16'(exp_g[i])));
      chk("rr_valid", 32'(valid_o), 32'h1);
    end

    // Backpressure for 4 cycles, then release (rr_ptr = 0)
    ready_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("bp_ready", 32'(ready_o), 32'h0);
      tick();
      chk("bp_data", 32'(data_o), 32'hC004);
      chk("bp_valid", 32'(valid_o), 32'h1);
    end
    ready_i = 1'b1;
    #1;
    chk("bp_release_ready", 32'(ready_o), 32'h01);
    tick();
    chk("bp_release_data", 32'(data_o), 32'hC000);
    chk("bp_release_grant", 32'(grant_o), 32'h0);
    valid_i = '0;
    tick();

    // Reset mid-packet: head from W (rr_ptr = 1, S idle so W wins)
    data_w_i = 16'h8001;
    valid_i  = 5'b00100;
    tick();
    valid_i = '0;
    chk("mr_locked_pre", 32'(locked_o), 32'h1);
    chk("mr_grant_pre", 32'(grant_o), 32'h2);
    #2;
    rst_ni = 1'b0;
    #1;
    chk("mr_valid", 32'(valid_o), 32'h0);
    chk("mr_locked", 32'(locked_o), 32'h0);
    chk("mr_grant", 32'(grant_o), 32'h0);
    tick();
    rst_ni   = 1'b1;
    data_s_i = 16'hC0B0;
    valid_i  = 5'b00010;
    #1;
    chk("mr_s_ready", 32'(ready_o), 32'h02);
    tick();
    chk("mr_s_data", 32'(data_o), 32'hC0B0);
    chk("mr_s_valid", 32'(valid_o), 32'h1);
    chk("mr_s_grant", 32'(grant_o), 32'h1);

    // Body on S while IDLE (rr_ptr = 2, only S valid)
    data_s_i = 16'h0055;
    #1;
    chk("tc_ready", 32'(ready_o), 32'h02);
    tick();
    valid_i = '0;
`ifdef NOC_ARB_TYPE_CHECK_EN
    chk("tc_valid", 32'(valid_o), 32'h0);
    chk("tc_locked", 32'(locked_o), 32'h0);
    chk("tc_err", 32'(err_o), 32'h1);
    tick();
    chk("tc_err_sticky", 32'(err_o), 32'h1);
`else
    chk("tc_valid", 32'(valid_o), 32'h1);
    chk("tc_data", 32'(data_o), 32'h0055);
    chk("tc_locked", 32'(locked_o), 32'h1);
    chk("tc_err", 32'(err_o), 32'h0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
